// File: rtl/regwrite_ctrl_if.sv
// Writeback request channel: a valid/ready handshake carrying a destination
// register index and its write data.
interface regwrite_ctrl_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;

    // Requester side: offers requests and observes acceptance.
    modport master (
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  wb_ready
    );

    // Controller side: consumes requests and signals acceptance.
    modport slave (
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output wb_ready
    );
endinterface : regwrite_ctrl_if

// File: rtl/regwrite_ctrl.sv
// Register-array write controller. Writeback requests are queued in a small
// in-order FIFO (with a bypass path when the FIFO is empty). Each drained
// entry drives a registered data bus G and a one-hot write enable R_in.
// A busy scoreboard tracks destinations of issued instructions until their
// write lands in the array.
module regwrite_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    regwrite_ctrl_if.slave     wb,
    input  logic               wr_hold,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    output logic               issue_stall,
    output logic [31:0]        G,
    output logic [31:0]        R_in,
    output logic [31:0]        busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic          push;
    logic          drain;
    logic          pop;
    logic          enq;
    logic [4:0]    src_rd;
    logic [31:0]   src_data;
    logic [31:0]   set_mask;
    logic [31:0]   busy_next;

    // One-hot decode of a register index; register 0 is never written.
    function automatic logic [31:0] onehot_rd(input logic [4:0] rd);
        logic [31:0] v;
        v    = 32'd1 << rd;
        v[0] = 1'b0;
        return v;
    endfunction

    // Acceptance depends only on registered occupancy.
    assign wb.wb_ready = (count < CW'(DEPTH));

    // Stall issue while the destination still has a write pending.
    assign issue_stall = (issue_rd != 5'd0) && busy[issue_rd];

    // Drain source selection, push/pop qualification and scoreboard update.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        fifo_empty = (count == '0);
        push       = wb.wb_valid && wb.wb_ready;
        drain      = !wr_hold && (!fifo_empty || push);
        pop        = drain && !fifo_empty;
        // A request drained straight through on an empty FIFO never enqueues.
        enq        = push && !(drain && fifo_empty);
        src_rd     = wb.wb_rd;
        src_data   = wb.wb_data;
        if (!fifo_empty) begin
            src_rd   = rd_mem[rd_ptr];
            src_data = data_mem[rd_ptr];
        end
        set_mask  = issue_valid ? onehot_rd(issue_rd) : '0;
        // Clear on the capture edge (R_in high), set applied last so it wins.
        busy_next = (busy & ~R_in) | set_mask;
    end

    // FIFO storage; entries are only read once pointers and count mark them valid.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; reset empties the
        // FIFO through the pointers and count, so stale contents are never read.
        if (enq) begin
            rd_mem[wr_ptr]   <= wb.wb_rd;
            data_mem[wr_ptr] <= wb.wb_data;
        end
    end

    // Pointers, occupancy, array write bus and scoreboard.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            G      <= '0;
            R_in   <= '0;
            busy   <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drain) begin
                G    <= src_data;
                R_in <= onehot_rd(src_rd);
            end else begin
                R_in <= '0;
            end
            busy <= busy_next;
        end
    end

endmodule : regwrite_ctrl

// File: doc/regwrite_ctrl.md
REGWRITE_CTRL -- requirements
Module: regwrite_ctrl

Interface
REQ-001 Parameter DEPTH, default 2: write-request FIFO depth; legal values are powers of two, at least 2.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 wb_valid  input  1  writeback request valid.
REQ-005 wb_rd  input  5  destination register index of the request.
REQ-006 wb_data  input  32  write data of the request.
REQ-007 wb_ready  output  1  request acceptance; a transfer occurs on an edge where wb_valid and wb_ready are both 1.
REQ-008 wr_hold  input  1  while 1, the block issues no register-array write.
REQ-009 issue_valid  input  1  an instruction with destination issue_rd is issued this cycle.
REQ-010 issue_rd  input  5  destination index of the issuing instruction.
REQ-011 issue_stall  output  1  combinational: busy[issue_rd], forced to 0 when issue_rd is 0.
REQ-012 G  output  32  registered write-data bus to the register array.
REQ-013 R_in  output  32  registered one-hot write enable to the register array; R_in[0] is always 0.
REQ-014 busy  output  32  registered scoreboard; bit n is 1 while a write to register n is pending.

Function
REQ-015 The FIFO holds {rd, data} entries in strict arrival order; wb_ready is 1 when occupancy is less than DEPTH, and depends only on registered state.
REQ-016 Drain happens on each edge where wr_hold is 0 and a source entry exists; the source is the FIFO head if the FIFO is non-empty, otherwise the request transferring on that edge (bypass).
REQ-017 On a drain edge, G loads the entry data and R_in loads one-hot(rd); if rd is 0, R_in loads 0 and the entry is still consumed.
REQ-018 On any non-drain edge, R_in loads 0 and G holds its value.
REQ-019 Latency: a request accepted into an empty FIFO with wr_hold at 0 has R_in/G valid in the next cycle, so the array captures it one edge after acceptance.
REQ-020 Push and pop on the same edge when full: not permitted, because wb_ready is 0; at occupancy 1 with hold at 0, push and pop are simultaneous and occupancy stays 1.
REQ-021 Read and write pointers wrap modulo DEPTH; occupancy is tracked with a counter of width log2(DEPTH)+1.
REQ-022 busy[n] is set on an edge where issue_valid is 1 and issue_rd equals n, for n not 0.
REQ-023 busy[n] is cleared on the edge where R_in[n] is 1, i.e. the array capture edge.
REQ-024 If set and clear of the same bit fall on the same edge, set wins.
REQ-025 busy[0] is constantly 0.
REQ-026 Upstream does not issue while issue_stall is 1; behaviour with two outstanding writers to one register is unspecified.
REQ-027 wr_hold has no effect on FIFO acceptance; requests still enqueue until the FIFO is full.

Reset
REQ-028 While resetn is 0, asynchronously: FIFO empty, pointers 0, R_in 0, G 0x00000000, busy 0; wb_ready therefore reads 1.
REQ-029 Reset asserted mid-operation discards all queued entries and pending busy bits; no R_in pulse occurs after reset release without a new request.
REQ-030 The first edge after resetn rises behaves as a normal operating edge.

Verification
REQ-031 Bypass: FIFO empty, hold 0, one request rd=5, data 0xDEADBEEF -> next cycle R_in=0x00000020 and G=0xDEADBEEF for exactly one cycle, then R_in=0.
REQ-032 Hold and fill: hold 1, requests rd=1/0x11, rd=2/0x22, rd=3/0x33 offered -> first two accepted, wb_ready 0 after the second; on hold release, R_in=0x2 then 0x4 on consecutive cycles with matching G, then the third request is accepted.
REQ-033 Scoreboard: issue rd=7 -> busy=0x80 and issue_stall 1 for issue_rd=7; after the rd=7 writeback, busy bit 7 clears on the R_in capture edge.
REQ-034 Set-wins: issue rd=9 on the same edge R_in[9] is 1 -> busy[9] remains 1.
REQ-035 rd=0: request rd=0, data 0x5 -> R_in stays 0, entry consumed, busy unchanged; issue_rd=0 -> issue_stall 0.
REQ-036 Reset mid-drain: two entries queued, resetn pulsed low between edges -> R_in, G and busy go to 0 immediately, wb_ready 1, and no write pulse follows.
